// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin sequencer that time-shares one 5-bit
// ripple-carry adder among four requesters with a valid/ready result port.

// Shared 5-bit ripple-carry adder, carry-in fixed at 0.
module BigAdder (
    input  logic [4:0] X,
    input  logic [4:0] Y,
    output logic [4:0] S,
    output logic       C5
);

    logic [5:0] c;

    // Ripple the carry bit by bit from the LSB.
    always_comb begin
        c = '0;
        S = '0;
        for (int i = 0; i < 5; i++) begin
            S[i]     = X[i] ^ Y[i] ^ c[i];
            c[i + 1] = (X[i] & Y[i]) | (c[i] & (X[i] ^ Y[i]));
        end
        C5 = c[5];
    end

endmodule

module adder_share_arb #(
    parameter int N_REQ = 4,
    parameter int W     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*W-1:0]   x_in,
    input  logic [N_REQ*W-1:0]   y_in,
    output logic [N_REQ-1:0]     gnt,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [1:0]           res_id,
    output logic [W-1:0]         res_sum,
    output logic                 res_c5
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [W-1:0]       x_q, x_d;
    logic [W-1:0]       y_q, y_d;
    logic [1:0]         id_q, id_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               valid_q, valid_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               c5_q, c5_d;
    logic [1:0]         rid_q, rid_d;

    logic [1:0]         win;
    logic               hit;
    logic [1:0]         idx;
    logic [W-1:0]       add_s;
    logic               add_c5;

    BigAdder u_add (
        .X  (x_q),
        .Y  (y_q),
        .S  (add_s),
        .C5 (add_c5)
    );

    // Round-robin pick: first set req bit at or after ptr, with wrap.
    always_comb begin
        win = '0;
        hit = 1'b0;
        idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr_q + 2'(k);
            if (!hit && req[idx]) begin
                win = idx;
                hit = 1'b1;
            end
        end
    end

    // Next-state and register updates for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        x_d     = x_q;
        y_d     = y_q;
        id_d    = id_q;
        gnt_d   = '0;
        valid_d = valid_q;
        sum_d   = sum_q;
        c5_d    = c5_q;
        rid_d   = rid_q;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    x_d     = x_in[win*W +: W];
                    y_d     = y_in[win*W +: W];
                    id_d    = win;
                    gnt_d   = N_REQ'(1) << win;
                    ptr_d   = win + 2'd1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                sum_d   = add_s;
                c5_d    = add_c5;
                rid_d   = id_q;
                valid_d = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset that discards in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            id_q    <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            c5_q    <= 1'b0;
            rid_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            id_q    <= id_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
            c5_q    <= c5_d;
            rid_q   <= rid_d;
        end
    end

    assign gnt       = gnt_q;
    assign res_valid = valid_q;
    assign res_id    = rid_q;
    assign res_sum   = sum_q;
    assign res_c5    = c5_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: scoreboard bench for the shared-adder arbiter.
// Grants are predicted by a round-robin model; results are queued and popped.

module tb_adder_share_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [19:0] x_in;
    logic [19:0] y_in;
    logic [3:0]  gnt;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [4:0]  res_sum;
    logic        res_c5;

    adder_share_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .x_in      (x_in),
        .y_in      (y_in),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_sum   (res_sum),
        .res_c5    (res_c5)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_pass = 0;
    int         cyc    = 0;
    logic [1:0] m_ptr  = 2'd0;
    logic       drop   = 1'b0;
    logic [7:0] sb_q[$];
    int         g_log[$];
    int         g_cyc[$];
    logic [7:0] hold;

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    function automatic int rr(logic [3:0] r, logic [1:0] p);
        logic [1:0] i;
        for (int k = 0; k < 4; k++) begin
            i = p + 2'(k);
            if (r[i]) return int'(i);
        end
        return -1;
    endfunction

    // One clock: capture inputs/outputs before the edge, check after it.
    task automatic step();
        logic [3:0]  req_e, gnt_e;
        logic        v_e, r_e, rst_e;
        logic [19:0] x_e, y_e;
        logic [5:0]  s6;
        logic [7:0]  e;
        int          w;
        req_e = req;  gnt_e = gnt;  v_e = res_valid;
        r_e = res_ready;  rst_e = rst;  x_e = x_in;  y_e = y_in;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_e) begin
            sb_q.delete();
            m_ptr = 2'd0;
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_vld", 32'(res_valid), 0);
            chk("rst_sum", 32'(res_sum), 0);
            chk("rst_id", 32'(res_id), 0);
            chk("rst_c5", 32'(res_c5), 0);
        end else begin
            if (gnt != 4'd0) begin
                w = rr(req_e, m_ptr);
                chk("gnt", 32'(gnt), (w < 0) ? 0 : (1 << w));
                chk("gnt_busy", {30'd0, gnt_e != 4'd0, v_e}, 0);
                if (w >= 0) begin
                    s6 = {1'b0, x_e[5*w +: 5]} + {1'b0, y_e[5*w +: 5]};
                    e = {2'(w), s6};
                    sb_q.push_back(e);
                    m_ptr = 2'(w + 1);
                    g_log.push_back(w);
                    g_cyc.push_back(cyc);
                end
                if (drop) req = req & ~gnt;
            end
            if (gnt_e != 4'd0) begin
                chk("lat_vld", 32'(res_valid), 1);
                chk("sb_nonempty", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("sb_id", 32'(res_id), 32'(e[7:6]));
                    chk("sb_c5", 32'(res_c5), 32'(e[5]));
                    chk("sb_sum", 32'(res_sum), 32'(e[4:0]));
                end
                hold = {res_id, res_c5, res_sum};
            end else if (v_e && !r_e) begin
                chk("bp_vld", 32'(res_valid), 1);
                chk("bp_hold", 32'({res_id, res_c5, res_sum}), 32'(hold));
                chk("bp_gnt", 32'(gnt), 0);
            end else if (v_e && r_e) begin
                chk("hs_drop", 32'(res_valid), 0);
            end else begin
                chk("no_spur_vld", 32'(res_valid), 0);
            end
        end
    endtask

    task automatic wait_gnt(int budget);
        for (int i = 0; i < budget && gnt == 4'd0; i++) step();
        chk("to_gnt", 32'(gnt != 4'd0), 1);
    endtask

    task automatic wait_vld(int budget);
        for (int i = 0; i < budget && !res_valid; i++) step();
        chk("to_vld", 32'(res_valid), 1);
    endtask

    task automatic op(int id, int x, int y, int es, int ec);
        x_in[5*id +: 5] = 5'(x);
        y_in[5*id +: 5] = 5'(y);
        req = 4'(1 << id);
        drop = 1'b1;
        res_ready = 1'b1;
        step();
        chk("op_gnt", 32'(gnt), 32'(1 << id));
        step();
        chk("op_vld", 32'(res_valid), 1);
        chk("op_id", 32'(res_id), 32'(id));
        chk("op_sum", 32'(res_sum), 32'(es));
        chk("op_c5", 32'(res_c5), 32'(ec));
        step();
    endtask

    int exp_ord[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        res_ready = 1'b1;
        x_in = 20'h12345;
        y_in = 20'h6789a;

        // Reset held two cycles with all requests pending.
        step();
        step();
        rst = 1'b0;
        drop = 1'b1;
        wait_gnt(10);
        chk("rst_first", 32'(gnt), 1);
        req = 4'd0;
        wait_vld(10);
        step();
        step();

        // Single request and overflow corners.
        op(2, 7, 9, 16, 0);
        op(0, 31, 31, 30, 1);
        op(3, 16, 16, 0, 1);
        op(1, 0, 0, 0, 0);

        // Fairness with every requester continuously asking.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x_in[5*i +: 5] = 5'(i);
            y_in[5*i +: 5] = 5'd10;
        end
        g_log.delete();
        g_cyc.delete();
        drop = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 40 && g_log.size() < 6; i++) step();
        chk("fair_cnt", 32'(g_log.size()), 6);
        for (int k = 0; k < g_log.size() && k < 6; k++) begin
            chk("fair_ord", 32'(g_log[k]), 32'(exp_ord[k]));
            if (k > 0) chk("fair_gap", 32'(g_cyc[k] - g_cyc[k-1]), 3);
        end
        req = 4'd0;
        step();
        step();
        step();

        // Backpressure: stall the result while others are requesting.
        drop = 1'b1;
        res_ready = 1'b0;
        x_in = 20'($urandom);
        y_in = 20'($urandom);
        req = 4'b1010;
        wait_vld(10);
        for (int i = 0; i < 5; i++) step();
        res_ready = 1'b1;
        step();
        chk("bp_drop", 32'(res_valid), 0);
        chk("bp_nog", 32'(gnt), 0);
        step();
        chk("bp_next", 32'(gnt), 32'(4'b0010));
        step();
        step();
        req = 4'd0;
        step();

        // Reset during the EXEC cycle of requester 1.
        x_in[9:5] = 5'd21;
        y_in[9:5] = 5'd13;
        req = 4'b0010;
        step();
        chk("rmo_gnt", 32'(gnt), 32'(4'b0010));
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b0011;
        step();
        chk("rmo_first", 32'(gnt), 1);
        step();
        step();
        req = 4'd0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
